traffic_conflict_monitor: RTL

Safety monitor downstream of the intersection light controller. It samples the north-south and east-west 3-bit light codes every clock and checks them for illegal codes, conflicting greens, illegal sequences, short yellow/all-red intervals and stuck phases. Legal codes are forwarded to the lamp drivers. On any violation it latches a fault and forces both approaches to flashing red until a supervised clear.

---
 rtl/traffic_conflict_monitor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the intersection light controller and the lamp drivers.
// It checks the sampled light codes, forwards legal ones and latches the first fault, which forces flashing red.
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 4,
  parameter int MIN_ALLRED = 4,
  parameter int MAX_PHASE  = 32,
  parameter int FLASH_HALF = 8,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_in,
  input  logic [2:0] ew_in,
  input  logic       clr,
  output logic [2:0] ns_out,
  output logic [2:0] ew_out,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_PHASE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(2 * FLASH_HALF - 1);

  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
  state_t state, state_next;

  logic [2:0]       s_ns, s_ew, p_ns, p_ew;
  logic [CNT_W-1:0] ns_dwell, ew_dwell, pair_dwell, allred_cnt;
  logic [CNT_W-1:0] flash_cnt, flash_next;
  logic             illegal, conflict, seq_bad, short_yel, short_allred, stuck;
  logic             s_allred, detect, do_clear;
  logic [2:0]       det_code;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  function automatic logic step_ok(input logic [2:0] p, input logic [2:0] s);
    return (s == p) || (p == GRN && s == YEL) || (p == YEL && s == RED) || (p == RED && s == GRN);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + CNT_ONE;
  endfunction

  // Counters describe the previous sample p_*, so a transition s vs p sees how long p was held.
  always_comb begin
    s_allred     = (s_ns == RED) && (s_ew == RED);
    illegal      = !is_legal(s_ns) || !is_legal(s_ew);
    conflict     = (s_ns != RED) && (s_ew != RED);
    seq_bad      = !step_ok(p_ns, s_ns) || !step_ok(p_ew, s_ew);
    short_yel    = (p_ns == YEL && s_ns == RED && ns_dwell < CNT_W'(MIN_YELLOW)) ||
                   (p_ew == YEL && s_ew == RED && ew_dwell < CNT_W'(MIN_YELLOW));
    short_allred = ((p_ns == RED && s_ns == GRN) || (p_ew == RED && s_ew == GRN)) &&
                   (allred_cnt < CNT_W'(MIN_ALLRED));
    stuck        = pair_dwell > CNT_W'(MAX_PHASE);
    det_code     = 3'd0;
    if (illegal)       det_code = 3'd1;
    else if (conflict) det_code = 3'd2;
    else if (state == RUN) begin
      if (seq_bad)           det_code = 3'd3;
      else if (short_yel)    det_code = 3'd4;
      else if (short_allred) det_code = 3'd5;
      else if (stuck)        det_code = 3'd6;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    detect     = 1'b0;
    do_clear   = 1'b0;
    flash_next = (flash_cnt >= FLASH_END) ? '0 : flash_cnt + CNT_ONE;
    case (state)
      INIT, RUN: begin
        detect     = (det_code != 3'd0);
        state_next = detect ? FAULT : RUN;
      end
      FAULT: begin
        do_clear = clr && s_allred;
        if (do_clear) state_next = INIT;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ns       <= RED;
      s_ew       <= RED;
      p_ns       <= RED;
      p_ew       <= RED;
      ns_dwell   <= '0;
      ew_dwell   <= '0;
      pair_dwell <= '0;
      allred_cnt <= '0;
      flash_cnt  <= '0;
      ns_out     <= RED;
      ew_out     <= RED;
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      s_ns <= ns_in;
      s_ew <= ew_in;
      p_ns <= s_ns;
      p_ew <= s_ew;
      if (state == INIT) begin
        ns_dwell   <= CNT_ONE;
        ew_dwell   <= CNT_ONE;
        pair_dwell <= CNT_ONE;
        allred_cnt <= s_allred ? CNT_ONE : '0;
      end else begin
        ns_dwell   <= (s_ns != p_ns) ? CNT_ONE : sat_inc(ns_dwell);
        ew_dwell   <= (s_ew != p_ew) ? CNT_ONE : sat_inc(ew_dwell);
        pair_dwell <= ({s_ns, s_ew} != {p_ns, p_ew}) ? CNT_ONE : sat_inc(pair_dwell);
        allred_cnt <= s_allred ? sat_inc(allred_cnt) : '0;
      end
      if (state == FAULT) begin
        if (do_clear) begin
          fault      <= 1'b0;
          fault_code <= 3'd0;
          flash_cnt  <= '0;
          ns_out     <= s_ns;
          ew_out     <= s_ew;
        end else begin
          flash_cnt <= flash_next;
          ns_out    <= (flash_next < CNT_W'(FLASH_HALF)) ? RED : OFF;
          ew_out    <= (flash_next < CNT_W'(FLASH_HALF)) ? RED : OFF;
        end
      end else if (detect) begin
        // The offending sample is replaced by red so it never reaches the lamps.
        fault      <= 1'b1;
        fault_code <= det_code;
        flash_cnt  <= '0;
        ns_out     <= RED;
        ew_out     <= RED;
      end else begin
        ns_out <= s_ns;
        ew_out <= s_ew;
      end
    end
  end
endmodule
